dm_lane_ctrl: RTL
=================

# dm_lane_ctrl

Parametrised successor to the single-cycle word data memory. It adds byte/halfword/word stores with byte enables, sign- or zero-extended sub-word loads, and a registered read port with a request/valid handshake. Misaligned and out-of-range access detection is built in. Post-reset zeroing is done by a sequential clear engine instead of a one-cycle array reset. It sits in the MEM stage behind the ALU address and feeds the MEM/WB register.

## Interface
- `DEPTH`, 3072: number of 32-bit words.
- `AW`, 12: word-index width; must satisfy 2^AW >= DEPTH.
- `Clk`  in  1: clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  1: access request, sampled when `ready`=1.
- `we`  in  1: 1 = store, 0 = load.
- `size`  in  2: access size; 00 byte, 01 half, 10 word, 11 reserved.
- `sign_ext`  in  1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr`  in  32: byte address; word index = `addr[AW+1:2]`, lane = `addr[1:0]`.
- `wd`  in  32: store data, right-justified.
- `pc`  in  32: PC of the requesting instruction (trace only).
- `ready`  out  1: block accepts a request this cycle.
- `busy`  out  1: clear engine running.
- `rvalid`  out  1: one-cycle pulse, `rd` valid.
- `rd`  out  32: extended load data.
- `err`  out  1: one-cycle pulse, previous accepted request was rejected.

## Operation
- FSM states are CLEAR and IDLE. Reset forces CLEAR with clear counter = 0.
  - CLEAR: writes 0 to word[counter], one word per cycle. `busy`=1, `ready`=0. When counter = DEPTH-1, the state moves to IDLE on that edge.
  - IDLE: `ready`=1, `busy`=0.
- Accept = `req` & `ready`.
- Reject on any of the following. A rejected access has no array write and no `rvalid`; `err`=1 on the next cycle.
  - `size`=11.
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - Word index ≥ DEPTH.
- Stores:
  - Byte: write `wd[7:0]` to lane `addr[1:0]`.
  - Half: write `wd[15:0]` to lanes {`addr[1]`,0}+1:0.
  - Word: write all lanes.
  - Unselected lanes keep their value.
- Loads:
  - Extract the addressed lane(s) from the word registered at accept.
  - Extend to 32 bits per `sign_ext`.
  - Word loads ignore `sign_ext`.
- Byte order is little-endian: lane 0 = bits 7:0.
- Only one request per cycle; stores never produce `rvalid`.

## Timing
- Reset values:
  - `ready`=0, `busy`=1, `rvalid`=0, `err`=0, `rd`=0.
  - Array contents are undefined until CLEAR completes.
- Clear takes exactly DEPTH cycles after reset deassertion; `ready` rises on cycle DEPTH.
- Load latency is 1: accept at edge N gives `rvalid`/`rd` during cycle N→N+1.
- `rd` holds its last value when `rvalid`=0.
- A store accepted at edge N updates the array at edge N. A load accepted at edge N+1 to the same word returns the new data; no bypass is needed.
- Back-to-back requests every cycle are supported, so throughput is 1 per cycle.
- `err` and `rvalid` are never both 1.
- Reset asserted mid-clear or mid-load: outputs go to reset values immediately and the clear restarts from word 0. A pending `rvalid` is lost.

## Configuration
- `DM_TRACE_EN` defined:
  - Every accepted, non-rejected store prints `"%d@%h: *%h <= %h"` with `$time`, `pc`, `addr` word-aligned (`addr[1:0]` forced to 0), and the full merged 32-bit word after the write.
  - Clear-engine writes are not printed.
- Undefined: no `$display`, and `pc` is unused.

## Test plan
- Reset held for 3 cycles, then released. Required: `busy`=1/`ready`=0 for exactly 3072 cycles. Then `ready`=1, and a load from word 3071 returns 0 with `rvalid` 1 cycle later.
- Store word 0x11223344 @0x10, then load byte @0x13 with `sign_ext`=0. Required: `rd`=0x00000011. Then store byte 0xF0 @0x11 and load half @0x10 with `sign_ext`=1. Required: `rd`=0xFFFFF044.
- Load half @0x21, word @0x22, `size`=11, and word @0x3000. Required: `err` pulses each next cycle, with no `rvalid` and no array change (verified by reload).
- Back-to-back: store 0xDEADBEEF @0x40 in cycle N, load word @0x40 in cycle N+1. Required: `rvalid` at N+2 with `rd`=0xDEADBEEF.
- Reset asserted at clear count 1000, then released. Required: clear restarts, `ready` rises exactly 3072 cycles after release, and the earlier store to @0x10 reads back 0.
- With `DM_TRACE_EN`, store byte 0xAB @0x13 with `pc`=0x3000 onto a zeroed word. Required: the line shows `00003000: *00000010 <= ab000000`.

Source files
------------

// File: rtl/dm_lane_ctrl.sv
`default_nettype none
// dm_lane_ctrl: byte-lane data memory with sequential clear engine and registered load port.
// Define DM_TRACE_EN to print every committed store. Revision 1.0.
module dm_lane_ctrl #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        busy,
  output logic        rvalid,
  output logic [31:0] rd,
  output logic        err
);

  localparam logic [0:0]    S_CLEAR  = 1'b0;
  localparam logic [0:0]    S_IDLE   = 1'b1;
  localparam int            AW1      = AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W  = AW1'(DEPTH);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]   mem_q [DEPTH];
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic [31:0]   rd_q, rd_d;

  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_accept;
  logic          w_reject;
  logic          w_store;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic          w_unused;

  assign w_idx    = addr[AW+1:2];
  assign w_lane   = addr[1:0];
  assign w_accept = req & ready;
  assign w_store  = w_accept & we & ~w_reject;
  assign w_old    = mem_q[w_idx];
  assign w_unused = ^{pc, addr[31:AW+2]};

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      if (clr_cnt_q == LAST_IDX) begin
        state_d   = S_IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    ready = (state_q == S_IDLE);
    busy  = (state_q == S_CLEAR);
  end

  always_comb begin
    w_reject = 1'b0;
    case (size)
      2'b01:   w_reject = addr[0];
      2'b10:   w_reject = |addr[1:0];
      2'b11:   w_reject = 1'b1;
      default: w_reject = 1'b0;
    endcase
    if ({1'b0, w_idx} >= DEPTH_W) w_reject = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = wd;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{wd[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wd[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      w_merged[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : w_old[8*i +: 8];
    end
  end

  always_comb begin
    w_byte = w_old[{w_lane, 3'b000} +: 8];
    w_half = addr[1] ? w_old[31:16] : w_old[15:0];
    case (size)
      2'b00:   w_load = {{24{sign_ext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{sign_ext & w_half[15]}}, w_half};
      default: w_load = w_old;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (w_store) begin
      mem_q[w_idx] <= w_merged;
`ifdef DM_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, w_merged);
`endif
    end
  end

  always_comb begin
    rvalid_d = w_accept & ~we & ~w_reject;
    err_d    = w_accept & w_reject;
    rd_d     = rvalid_d ? w_load : rd_q;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rd     = rd_q;

endmodule
`default_nettype wire
